// File: rtl/des_pkg.sv
// Shared DES constants: permutation index tables, S-boxes, key shift schedule,
// engine state and round-counter types.
package des_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [3:0] round_t;

  // Round 16 is encoded as 0: the 4-bit counter wraps after round 15.
  localparam round_t ROUND_FIRST = 4'd1;
  localparam round_t ROUND_LAST  = 4'd0;

  // Bit n set => round n (16 encoded as bit 0) uses a single-position shift.
  localparam logic [15:0] SHIFT1_ENC = 16'h0207;
  localparam logic [15:0] SHIFT1_DEC = 16'h0205;
  localparam logic [15:0] SHIFT0_DEC = 16'h0002;

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int unsigned SBOX_T [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] o;
    for (int unsigned i = 0; i < 56; i++) o[i] = k[PC1_T[i] - 1];
    return o;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] o;
    for (int unsigned i = 0; i < 48; i++) o[i] = cd[PC2_T[i] - 1];
    return o;
  endfunction

  function automatic logic [0:47] e_expand(input logic [0:31] r);
    logic [0:47] o;
    for (int unsigned i = 0; i < 48; i++) o[i] = r[E_T[i] - 1];
    return o;
  endfunction

  function automatic logic [0:31] p_perm(input logic [0:31] s);
    logic [0:31] o;
    for (int unsigned i = 0; i < 32; i++) o[i] = s[P_T[i] - 1];
    return o;
  endfunction

  // Row from the outer bits, column from the inner four.
  function automatic logic [3:0] sbox(input int unsigned n, input logic [0:5] x);
    logic [5:0] idx;
    idx = {x[0], x[5], x[1:4]};
    return 4'(SBOX_T[n][idx]);
  endfunction

  function automatic logic [1:0] shift_amt(input round_t rnd, input logic dec);
    logic [15:0] one_mask;
    one_mask = dec ? SHIFT1_DEC : SHIFT1_ENC;
    if (dec && SHIFT0_DEC[rnd]) return 2'd0;
    return one_mask[rnd] ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [0:27] rot28(input logic [0:27] v, input logic [1:0] amt,
                                        input logic right);
    case ({right, amt})
      3'b001:  return {v[1:27], v[0]};
      3'b010:  return {v[2:27], v[0:1]};
      3'b101:  return {v[27], v[0:26]};
      3'b110:  return {v[26:27], v[0:25]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/des_f_func.sv
// DES round function f(R,K) = P(S1..S8(E(R) xor K)); purely combinational.
module des_f_func
  import des_pkg::*;
(
  input  logic [0:31] r,
  input  logic [0:47] k,
  output logic [0:31] f
);

  logic [0:47] x;
  logic [0:31] s_out;

  assign x = e_expand(r) ^ k;

  always_comb begin
    s_out = '0;
    for (int unsigned i = 0; i < 8; i++) s_out[4*i +: 4] = sbox(i, x[6*i +: 6]);
  end

  assign f = p_perm(s_out);

endmodule

// File: rtl/des_round_iter.sv
// Iterative DES Feistel core: one round per clock between IP and FP stages,
// encrypt or decrypt selected per block by subkey-order reversal.
module des_round_iter
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] in_data,
  input  logic [0:63] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] out_data
);

  state_t      state;
  round_t      round;
  logic        mode;
  logic [0:31] l_q, r_q;
  logic [0:27] c_q, d_q;
  logic [0:27] c_rot, d_rot;
  logic [1:0]  amt;
  logic [0:47] subkey;
  logic [0:31] f_out;
  logic [0:55] cd_init;
  logic        accept;

  assign amt     = shift_amt(round, mode);
  assign c_rot   = rot28(c_q, amt, mode);
  assign d_rot   = rot28(d_q, amt, mode);
  assign subkey  = pc2({c_rot, d_rot});
  assign cd_init = pc1(in_key);

  des_f_func u_f (
    .r(r_q),
    .k(subkey),
    .f(f_out)
  );

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Accept takes priority so a DONE-state handshake can reload in the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      round     <= '0;
      mode      <= 1'b0;
      l_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      l_q       <= in_data[0:31];
      r_q       <= in_data[32:63];
      c_q       <= cd_init[0:27];
      d_q       <= cd_init[28:55];
      mode      <= in_decrypt;
      round     <= ROUND_FIRST;
      out_valid <= 1'b0;
      state     <= RUN;
    end else begin
      case (state)
        RUN: begin
          l_q   <= r_q;
          r_q   <= l_q ^ f_out;
          c_q   <= c_rot;
          d_q   <= d_rot;
          round <= round + 4'd1;
          if (round == ROUND_LAST) begin
            out_data  <= {l_q ^ f_out, r_q};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_iter.sv
// Directed scoreboard bench for des_round_iter using FIPS 46-3 reference vectors.
module tb_des_round_iter;

  localparam logic [63:0] KEY    = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT_IP  = 64'hCC00CCFFF0AAF0AA;
  localparam logic [63:0] CT_PRE = 64'h0A4CD99543423234;

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  typedef struct packed {
    logic        fp;
    logic [63:0] exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:63] in_data;
  logic [0:63] in_key;
  logic        in_decrypt;
  logic        out_valid;
  logic        out_ready;
  logic [0:63] out_data;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  sb_t         sb[$];

  des_round_iter dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_key(in_key), .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [0:63] fp_perm(input logic [0:63] v);
    logic [0:63] o;
    for (int unsigned i = 0; i < 64; i++) o[i] = v[FP_T[i] - 1];
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic drive_accept(input logic [63:0] d, input logic [63:0] k, input logic dec);
    in_valid   = 1'b1;
    in_data    = d;
    in_key     = k;
    in_decrypt = dec;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat = edges after the accept edge until out_valid is seen; optional input noise.
  task automatic await_out(input int unsigned noise_until, output int unsigned lat,
                           output logic saw_rdy);
    lat = 0;
    saw_rdy = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) saw_rdy = 1'b1;
      if (lat < noise_until) begin
        in_valid   = 1'($urandom_range(0, 1));
        in_data    = {$urandom(), $urandom()};
        in_key     = {$urandom(), $urandom()};
        in_decrypt = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag);
    sb_t         e;
    logic [63:0] got;
    check({tag, "_sb_level"}, 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      got = e.fp ? fp_perm(out_data) : out_data;
      check(tag, got, e.exp);
    end
  endtask

  initial begin
    int unsigned lat;
    logic        saw;
    logic        stable, rdy_seen, any_valid;
    logic [0:63] held;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; in_decrypt = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_data",  out_data,       64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS encrypt with K1 probe during round 1
    sb.push_back('{fp: 1'b0, exp: CT_PRE});
    drive_accept(PT_IP, KEY, 1'b0);
    check("k1_probe", 64'(dut.subkey), 64'h00001B02EFFC7072);
    await_out(0, lat, saw);
    check("enc_latency", 64'(lat), 64'd16);
    check("enc_run_in_ready", 64'(saw), 64'd0);
    check_result("enc_fips");
    @(negedge clk);
    check("enc_valid_drop", 64'(out_valid), 64'd0);

    // FIPS decrypt
    sb.push_back('{fp: 1'b0, exp: PT_IP});
    drive_accept(CT_PRE, KEY, 1'b1);
    await_out(0, lat, saw);
    check("dec_latency", 64'(lat), 64'd16);
    check_result("dec_fips");
    @(negedge clk);

    // all-zero key and block, checked through the final permutation
    sb.push_back('{fp: 1'b1, exp: 64'h8CA64DE9C1B123A7});
    drive_accept(64'd0, 64'd0, 1'b0);
    await_out(0, lat, saw);
    check_result("zero_fp");
    @(negedge clk);

    // backpressure, then handshake with simultaneous accept
    out_ready = 1'b0;
    sb.push_back('{fp: 1'b0, exp: CT_PRE});
    drive_accept(PT_IP, KEY, 1'b0);
    await_out(0, lat, saw);
    held = out_data;
    stable = 1'b1;
    rdy_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_data !== held || !out_valid) stable = 1'b0;
      if (in_ready) rdy_seen = 1'b1;
    end
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_in_ready", 64'(rdy_seen), 64'd0);
    check_result("bp_held");
    out_ready = 1'b1;
    sb.push_back('{fp: 1'b0, exp: PT_IP});
    drive_accept(CT_PRE, KEY, 1'b1);
    await_out(0, lat, saw);
    check("bp_b2b_latency", 64'(lat), 64'd16);
    check_result("bp_b2b_dec");

    // streaming: accept on the same edge as the output handshake
    sb.push_back('{fp: 1'b0, exp: CT_PRE});
    drive_accept(PT_IP, KEY, 1'b0);
    await_out(0, lat, saw);
    check("stream_period", 64'(lat + 1), 64'd17);
    check_result("stream_enc");
    @(negedge clk);

    // reset during round 8 aborts the block
    drive_accept(PT_IP, KEY, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_data",  out_data,       64'd0);
    rst_n = 1'b1;
    any_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) any_valid = 1'b1;
    end
    check("midrst_no_output", 64'(any_valid), 64'd0);

    sb.push_back('{fp: 1'b0, exp: CT_PRE});
    drive_accept(PT_IP, KEY, 1'b0);
    await_out(0, lat, saw);
    check_result("post_rst_enc");
    @(negedge clk);

    // input noise during RUN must be ignored
    sb.push_back('{fp: 1'b0, exp: CT_PRE});
    drive_accept(PT_IP, KEY, 1'b0);
    await_out(15, lat, saw);
    check("noise_latency", 64'(lat), 64'd16);
    check_result("noise_enc");
    @(negedge clk);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
